uart_gpio_bridge: RTL
=====================

# uart_gpio_bridge

Parametrised UART-to-GPIO bridge: a host on a serial link writes any byte of a multi-byte output register, reads any byte of a sampled input bus, and the fabric can push a full input snapshot on demand. It replaces the fixed 8-bit LED/switch serial bridge in the board top level. It sits between the board UART pins and the LED/switch banks, with its own oversampling baud generator.

## Interface
- CLK_HZ, 100000000, system clock frequency in Hz
- BAUD, 9600, line rate in bit/s
- GPIO_BYTES, 1, byte lanes on gpio_out and gpio_in; legal range 1..16
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- rxd  input  1  serial in, idle high, asynchronous to clk (2-flop synchronised inside)
- txd  output  1  serial out, idle high
- gpio_out  output  8*GPIO_BYTES  host-written register (LED bank)
- gpio_in  input  8*GPIO_BYTES  sampled input bus (switch bank)
- report_req  input  1  rising edge requests a snapshot report
- busy  output  1  high while a byte is in transmission or a transmission is pending
- frame_err  output  1  one-cycle pulse on a bad stop bit (or parity, see Configuration)

## Operation
- Reset values: txd=1, gpio_out=0, busy=0, frame_err=0; parser in CMD, TX idle, no pending requests.
- Framing: 8 data bits LSB first, 1 stop bit; 16x oversampling. Divisor DIV = round(CLK_HZ/(BAUD*16)); counter width = $clog2(DIV).
- RX: start bit confirmed low at oversample tick 8, then data/stop sampled every 16 ticks. Start glitch (high at tick 8) -> back to idle, no error.
- Command byte: bit7 = 1 write, 0 read; bits[3:0] = lane index; bits[6:4] ignored.
- Parser states: CMD -> (write) DATA -> CMD; CMD -> (read) queue reply, stay CMD.
- Write: byte received in DATA stored to gpio_out[8*idx +: 8]. idx >= GPIO_BYTES: data byte consumed and discarded, gpio_out unchanged.
- Read: gpio_in[8*idx +: 8] sampled on the cycle the command completes; reply sent. idx >= GPIO_BYTES: reply 0xEE (NAK).
- Report: rising edge of report_req (edge-detected on clk) snapshots all of gpio_in that cycle; sends header 0xA5 then lanes 0..GPIO_BYTES-1.
- Frame error: frame_err pulses, byte dropped, parser forced to CMD.
- TX arbitration: one pending-reply slot and one pending-report flag. Reply has priority over report at byte boundaries; a report, once its header is sent, is not interleaved. A second read arriving while the reply slot is full overwrites the slot (latest wins). report_req edges while a report is pending or in progress are ignored.

## Timing
- gpio_out updates 1 clk after the stop-bit sample of the data byte.
- Read reply: txd start bit begins within 2 clk of the command stop-bit sample when TX is idle.
- Report header start bit begins within 2 clk of the detected report_req edge when TX is idle.
- Bytes of a report are back-to-back: next start bit immediately follows the prior stop bit.
- busy rises the cycle a request is accepted and falls the cycle the last stop bit ends with nothing pending.
- Reset asserted mid-byte: txd high and gpio_out zero immediately (asynchronous); the partial RX byte is lost.

## Configuration
- UART_GPIO_PARITY_EN defined: even parity bit after data bit 7 in both directions (8E1). RX parity mismatch is treated as a frame error (pulse, drop, parser to CMD).
- Not defined: 8N1, no parity logic present.

## Structure
- Package uart_gpio_pkg: command bit positions (CMD_WRITE_BIT=7, index field [3:0]), HDR_BYTE=8'hA5, NAK_BYTE=8'hEE, OVERSAMPLE=16, parser/RX/TX state enums.
- Sub-module uart_oversample_tick: parametrised by DIV, emits a one-clk tick every DIV cycles, shared by RX and TX.

## Test plan
- GPIO_BYTES=2: send 0x81, 0x3C -> gpio_out = 16'h3C00 one clk after the stop bit; no reply on txd.
- gpio_in=16'hBEEF, send 0x00 -> txd carries 0xEF; send 0x01 -> 0xBE.
- Send read 0x05 with GPIO_BYTES=2 -> reply 0xEE; send write 0x85, 0x77 -> gpio_out unchanged.
- Pulse report_req with gpio_in=16'h1234 -> txd sends 0xA5, 0x34, 0x12 back-to-back; busy high throughout.
- Drive a byte with stop bit low -> frame_err one-cycle pulse, nothing written; following 0x80, 0x55 -> lane 0 = 0x55.
- Assert reset mid-report -> txd=1 and busy=0 immediately, gpio_out=0; next read works normally.

Source files
------------

// File: rtl/uart_gpio_pkg.sv
// rtl/uart_gpio_pkg.sv - shared constants for the UART-to-GPIO bridge
// Command layout, protocol bytes, oversampling ratio and FSM state codes.
package uart_gpio_pkg;

  localparam int         CMD_WRITE_BIT = 7;
  localparam int         CMD_IDX_MSB   = 3;
  localparam int         CMD_IDX_LSB   = 0;
  localparam logic [7:0] HDR_BYTE      = 8'hA5;
  localparam logic [7:0] NAK_BYTE      = 8'hEE;
  localparam int         OVERSAMPLE    = 16;

  localparam logic       PAR_CMD  = 1'b0;
  localparam logic       PAR_DATA = 1'b1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_BITS  = 2'd2;

  localparam logic       TX_IDLE = 1'b0;
  localparam logic       TX_SEND = 1'b1;

  function automatic logic [3:0] cmd_index(input logic [7:0] cmd);
    return cmd[CMD_IDX_MSB:CMD_IDX_LSB];
  endfunction

endpackage

// File: rtl/uart_oversample_tick.sv
// rtl/uart_oversample_tick.sv - one-clock tick every DIV cycles
// Shared 16x baud oversampling strobe for the RX and TX engines.
module uart_oversample_tick #(
  parameter int DIV = 651
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] r_cnt;
  logic         r_tick;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == W'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_gpio_bridge.sv
// rtl/uart_gpio_bridge.sv - UART host access to a multi-byte GPIO register
// Build option: define UART_GPIO_PARITY_EN for 8E1 framing (default 8N1).
module uart_gpio_bridge #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int GPIO_BYTES = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_rxd,
  output logic                    o_txd,
  output logic [8*GPIO_BYTES-1:0] o_gpio_out,
  input  logic [8*GPIO_BYTES-1:0] i_gpio_in,
  input  logic                    i_report_req,
  output logic                    o_busy,
  output logic                    o_frame_err
);

  import uart_gpio_pkg::*;

  localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
`ifdef UART_GPIO_PARITY_EN
  localparam int RXW = 9;
  localparam int TXW = 11;
`else
  localparam int RXW = 8;
  localparam int TXW = 10;
`endif

  logic w_tick;

  uart_oversample_tick #(.DIV(DIV)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (w_tick)
  );

  logic [1:0]     r_rx_sync;
  logic [1:0]     r_rx_state;
  logic [3:0]     r_rx_tick;
  logic [3:0]     r_rx_bit;
  logic [RXW-1:0] r_rx_shift;
  logic           r_rx_valid;
  logic [7:0]     r_rx_data;
  logic           r_frame_err;
  logic           w_rxd;
  logic           w_rx_ok;

  assign w_rxd = r_rx_sync[1];
`ifdef UART_GPIO_PARITY_EN
  assign w_rx_ok = w_rxd & (r_rx_shift[8] == ^r_rx_shift[7:0]);
`else
  assign w_rx_ok = w_rxd;
`endif

  // Start bit is re-checked half a bit in; every later sample lands mid-bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_sync   <= 2'b11;
      r_rx_state  <= RX_IDLE;
      r_rx_tick   <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_sync   <= {r_rx_sync[0], i_rxd};
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rxd) begin
            r_rx_state <= RX_START;
            r_rx_tick  <= '0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_tick == 4'(OVERSAMPLE / 2 - 1)) begin
              r_rx_tick  <= '0;
              r_rx_bit   <= '0;
              r_rx_state <= w_rxd ? RX_IDLE : RX_BITS;
            end else begin
              r_rx_tick <= r_rx_tick + 4'd1;
            end
          end
        end
        RX_BITS: begin
          if (w_tick) begin
            r_rx_tick <= r_rx_tick + 4'd1;
            if (r_rx_tick == 4'(OVERSAMPLE - 1)) begin
              if (r_rx_bit == 4'(RXW)) begin
                r_rx_state <= RX_IDLE;
                if (w_rx_ok) begin
                  r_rx_valid <= 1'b1;
                  r_rx_data  <= r_rx_shift[7:0];
                end else begin
                  r_frame_err <= 1'b1;
                end
              end else begin
                r_rx_shift <= {w_rxd, r_rx_shift[RXW-1:1]};
                r_rx_bit   <= r_rx_bit + 4'd1;
              end
            end
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  logic                    r_par_state;
  logic [3:0]              r_wr_idx;
  logic [8*GPIO_BYTES-1:0] r_gpio_out;
  logic                    r_reply_pend;
  logic [7:0]              r_reply_byte;
  logic                    r_rep_pend;
  logic                    r_rep_inprog;
  logic [8*GPIO_BYTES-1:0] r_snap;
  logic                    r_req_d;
  logic [4:0]              r_rep_left;
  logic [3:0]              r_rep_lane;
  logic                    r_tx_state;
  logic [TXW-1:0]          r_tx_frame;
  logic [3:0]              r_tx_tick;
  logic [3:0]              r_tx_bit;

  logic       w_rd_ok;
  logic [7:0] w_rd_lane;
  logic       w_wr_ok;
  logic [7:0] w_rep_byte;

  always_comb begin
    w_rd_ok    = 1'b0;
    w_rd_lane  = '0;
    w_wr_ok    = 1'b0;
    w_rep_byte = '0;
    for (int l = 0; l < GPIO_BYTES; l++) begin
      if (cmd_index(r_rx_data) == 4'(l)) begin
        w_rd_ok   = 1'b1;
        w_rd_lane = i_gpio_in[8*l +: 8];
      end
      if (r_wr_idx == 4'(l)) w_wr_ok = 1'b1;
      if (r_rep_lane == 4'(l)) w_rep_byte = r_snap[8*l +: 8];
    end
  end

  logic           w_bit_end;
  logic           w_byte_end;
  logic           w_boundary;
  logic           w_load_lane;
  logic           w_load_reply;
  logic           w_load_hdr;
  logic           w_load;
  logic           w_rep_done;
  logic           w_req_rise;
  logic [7:0]     w_tx_byte;
  logic [TXW-1:0] w_tx_frame;

  assign w_bit_end    = (r_tx_state == TX_SEND) && w_tick && (r_tx_tick == 4'(OVERSAMPLE - 1));
  assign w_byte_end   = w_bit_end && (r_tx_bit == 4'(TXW - 1));
  assign w_boundary   = (r_tx_state == TX_IDLE) || w_byte_end;
  // An in-flight report owns the line until its last lane; replies wait.
  assign w_load_lane  = w_boundary && (r_rep_left != 5'd0);
  assign w_load_reply = w_boundary && (r_rep_left == 5'd0) && r_reply_pend;
  assign w_load_hdr   = w_boundary && (r_rep_left == 5'd0) && !r_reply_pend && r_rep_pend;
  assign w_load       = w_load_lane || w_load_reply || w_load_hdr;
  assign w_rep_done   = w_byte_end && r_rep_inprog && (r_rep_left == 5'd0);
  assign w_req_rise   = i_report_req && !r_req_d;
  assign w_tx_byte    = w_load_lane ? w_rep_byte : (w_load_reply ? r_reply_byte : HDR_BYTE);
`ifdef UART_GPIO_PARITY_EN
  assign w_tx_frame   = {1'b1, ^w_tx_byte, w_tx_byte, 1'b0};
`else
  assign w_tx_frame   = {1'b1, w_tx_byte, 1'b0};
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_par_state  <= PAR_CMD;
      r_wr_idx     <= '0;
      r_gpio_out   <= '0;
      r_reply_pend <= 1'b0;
      r_reply_byte <= '0;
      r_rep_pend   <= 1'b0;
      r_snap       <= '0;
      r_req_d      <= 1'b0;
    end else begin
      r_req_d <= i_report_req;
      if (w_load_reply) r_reply_pend <= 1'b0;
      if (w_load_hdr) begin
        r_rep_pend <= 1'b0;
      end else if (w_req_rise && !r_rep_pend && !r_rep_inprog) begin
        r_rep_pend <= 1'b1;
        r_snap     <= i_gpio_in;
      end
      if (r_frame_err) begin
        r_par_state <= PAR_CMD;
      end else if (r_rx_valid) begin
        if (r_par_state == PAR_CMD) begin
          if (r_rx_data[CMD_WRITE_BIT]) begin
            r_par_state <= PAR_DATA;
            r_wr_idx    <= cmd_index(r_rx_data);
          end else begin
            r_reply_pend <= 1'b1;
            r_reply_byte <= w_rd_ok ? w_rd_lane : NAK_BYTE;
          end
        end else begin
          r_par_state <= PAR_CMD;
          if (w_wr_ok) begin
            for (int l = 0; l < GPIO_BYTES; l++) begin
              if (r_wr_idx == 4'(l)) r_gpio_out[8*l +: 8] <= r_rx_data;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_state   <= TX_IDLE;
      r_tx_frame   <= '1;
      r_tx_tick    <= '0;
      r_tx_bit     <= '0;
      r_rep_inprog <= 1'b0;
      r_rep_left   <= '0;
      r_rep_lane   <= '0;
    end else begin
      if (w_load) begin
        r_tx_state <= TX_SEND;
        r_tx_frame <= w_tx_frame;
        r_tx_tick  <= '0;
        r_tx_bit   <= '0;
      end else if (w_bit_end) begin
        if (w_byte_end) r_tx_state <= TX_IDLE;
        r_tx_frame <= {1'b1, r_tx_frame[TXW-1:1]};
        r_tx_bit   <= r_tx_bit + 4'd1;
        r_tx_tick  <= r_tx_tick + 4'd1;
      end else if ((r_tx_state == TX_SEND) && w_tick) begin
        r_tx_tick <= r_tx_tick + 4'd1;
      end
      if (w_load_hdr) begin
        r_rep_inprog <= 1'b1;
        r_rep_left   <= 5'(GPIO_BYTES);
        r_rep_lane   <= '0;
      end else begin
        if (w_load_lane) begin
          r_rep_left <= r_rep_left - 5'd1;
          r_rep_lane <= r_rep_lane + 4'd1;
        end
        if (w_rep_done) r_rep_inprog <= 1'b0;
      end
    end
  end

  assign o_txd       = r_tx_frame[0];
  assign o_gpio_out  = r_gpio_out;
  assign o_busy      = (r_tx_state == TX_SEND) || r_reply_pend || r_rep_pend;
  assign o_frame_err = r_frame_err;

endmodule
